// File: rtl/key_expand.sv
`default_nettype none
// ============================================================================
// Module   : key_expand
// Brief    : Iterative AES-128 key expansion, one round key per clock.
// Revision : 1.0
// ============================================================================
module key_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] aes_key,
    output logic [127:0] key1,
    output logic [127:0] key2,
    output logic [127:0] key3,
    output logic [127:0] key4,
    output logic [127:0] key5,
    output logic [127:0] key6,
    output logic [127:0] key7,
    output logic [127:0] key8,
    output logic [127:0] key9,
    output logic [127:0] key10,
    output logic         busy,
    output logic         done
);

    localparam logic c_IDLE = 1'b0;
    localparam logic c_RUN  = 1'b1;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         r_state;
    logic         w_state_next;
    logic [3:0]   r_rnd;
    logic [127:0] r_work;
    logic [127:0] r_keys [10];
    logic         r_done;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_temp;
    logic [127:0] w_next;

    assign w_rot = {r_work[23:0], r_work[31:24]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            assign w_sub[8*b +: 8] = c_SBOX[11'd2047 - {w_rot[8*b +: 8], 3'b000} -: 8];
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Each new word chains off the previous new word of the same round key.
    assign w_temp          = w_sub ^ {w_rcon, 24'h000000};
    assign w_next[127:96]  = r_work[127:96] ^ w_temp;
    assign w_next[95:64]   = r_work[95:64]  ^ w_next[127:96];
    assign w_next[63:32]   = r_work[63:32]  ^ w_next[95:64];
    assign w_next[31:0]    = r_work[31:0]   ^ w_next[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_RUN;
            c_RUN:   if (r_rnd == 4'd10) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_RUN);
        done = r_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rnd  <= 4'd0;
            r_work <= 128'd0;
            r_done <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                r_keys[i] <= 128'd0;
            end
        end else begin
            r_done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    r_work <= aes_key;
                    r_rnd  <= 4'd1;
                end
            end else begin
                r_work <= w_next;
                for (int i = 0; i < 10; i++) begin
                    if (r_rnd == 4'(i + 1)) begin
                        r_keys[i] <= w_next;
                    end
                end
                if (r_rnd == 4'd10) begin
                    r_rnd  <= 4'd0;
                    r_done <= 1'b1;
                end else begin
                    r_rnd  <= r_rnd + 4'd1;
                end
            end
        end
    end

    assign key1  = r_keys[0];
    assign key2  = r_keys[1];
    assign key3  = r_keys[2];
    assign key4  = r_keys[3];
    assign key5  = r_keys[4];
    assign key6  = r_keys[5];
    assign key7  = r_keys[6];
    assign key8  = r_keys[7];
    assign key9  = r_keys[8];
    assign key10 = r_keys[9];

endmodule
`default_nettype wire

// File: tb/tb_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_expand
// Brief    : Randomized self-checking bench for key_expand against a FIPS-197 model.
// Revision : 1.0
// ============================================================================
module tb_key_expand;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] aes_key;
    logic [127:0] key1, key2, key3, key4, key5, key6, key7, key8, key9, key10;
    logic         busy;
    logic         done;

    logic [127:0] keys_out [10];
    logic [127:0] exp_keys [10];
    logic [7:0]   sbox_t [256];
    int           n_checks = 0;
    int           n_fail   = 0;

    key_expand dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .aes_key (aes_key),
        .key1    (key1),
        .key2    (key2),
        .key3    (key3),
        .key4    (key4),
        .key5    (key5),
        .key6    (key6),
        .key7    (key7),
        .key8    (key8),
        .key9    (key9),
        .key10   (key10),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        keys_out[0] = key1;
        keys_out[1] = key2;
        keys_out[2] = key3;
        keys_out[3] = key4;
        keys_out[4] = key5;
        keys_out[5] = key6;
        keys_out[6] = key7;
        keys_out[7] = key8;
        keys_out[8] = key9;
        keys_out[9] = key10;
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Round key n (1..10) of the FIPS-197 word schedule.
    function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                rc = 8'h01;
                for (int r = 1; r < i / 4; r++) rc = gmul(rc, 8'h02);
                t = t ^ {rc, 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_keys(input string tag, input logic [127:0] key);
        for (int m = 1; m <= 10; m++) begin
            check_eq($sformatf("%s_key%0d", tag, m), keys_out[m-1], round_key(key, m));
        end
    endtask

    // Launch one expansion and check every output after each of edges 0..10.
    task automatic run_expand(input logic [127:0] key, input bit noisy);
        logic [127:0] rk [10];
        logic [127:0] want;
        for (int m = 1; m <= 10; m++) rk[m-1] = round_key(key, m);
        start   = 1'b1;
        aes_key = key;
        step();
        check_eq("busy_edge0", 128'(busy), 128'(1));
        check_eq("done_edge0", 128'(done), 128'(0));
        for (int n = 1; n <= 10; n++) begin
            if (noisy) begin
                start   = 1'($urandom_range(0, 1));
                aes_key = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            step();
            for (int m = 1; m <= 10; m++) begin
                want = (m <= n) ? rk[m-1] : exp_keys[m-1];
                check_eq($sformatf("key%0d_edge%0d", m, n), keys_out[m-1], want);
            end
            check_eq($sformatf("busy_edge%0d", n), 128'(busy), 128'(n < 10));
            check_eq($sformatf("done_edge%0d", n), 128'(done), 128'(n == 10));
        end
        start = 1'b0;
        for (int m = 0; m < 10; m++) exp_keys[m] = rk[m];
    endtask

    initial begin
        logic [127:0] ka, kb;
        build_sbox();
        reset   = 1'b1;
        start   = 1'b0;
        aes_key = 128'd0;
        for (int m = 0; m < 10; m++) exp_keys[m] = 128'd0;
        step();
        step();
        for (int m = 1; m <= 10; m++) check_eq($sformatf("reset_key%0d", m), keys_out[m-1], 128'd0);
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_done", 128'(done), 128'(0));
        reset = 1'b0;

        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        check_eq("kat1_key1", key1, 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("kat1_key10", key10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        step();
        check_eq("kat1_done_drop", 128'(done), 128'(0));

        run_expand(128'h534f4d452031323820424954204b4559, 1'b1);
        check_eq("kat2_key1", key1, 128'he12186f2c110b4cae152fd9ec119b8c7);
        step();

        run_expand(128'd0, 1'b0);
        check_eq("kat3_key1", key1, 128'h62636363626363636263636362636363);
        check_eq("kat3_key10", key10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        step();

        for (int i = 0; i < 6; i++) begin
            run_expand({$urandom, $urandom, $urandom, $urandom}, i[0]);
            step();
            check_eq("rand_idle_busy", 128'(busy), 128'(0));
        end

        // start held high: a new capture happens in the done cycle's edge.
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        start   = 1'b1;
        aes_key = ka;
        step();
        aes_key = kb;
        for (int n = 1; n <= 10; n++) step();
        check_all_keys("b2b_a", ka);
        check_eq("b2b_done_a", 128'(done), 128'(1));
        check_eq("b2b_busy_a", 128'(busy), 128'(0));
        step();
        check_eq("b2b_busy_restart", 128'(busy), 128'(1));
        check_eq("b2b_done_restart", 128'(done), 128'(0));
        start = 1'b0;
        for (int n = 1; n <= 10; n++) step();
        check_all_keys("b2b_b", kb);
        check_eq("b2b_done_b", 128'(done), 128'(1));
        for (int m = 0; m < 10; m++) exp_keys[m] = round_key(kb, m + 1);
        step();

        // Reset lands on edge 5 of an expansion.
        start   = 1'b1;
        aes_key = {$urandom, $urandom, $urandom, $urandom};
        step();
        start = 1'b0;
        for (int n = 1; n <= 4; n++) step();
        reset = 1'b1;
        step();
        for (int m = 1; m <= 10; m++) check_eq($sformatf("abort_key%0d", m), keys_out[m-1], 128'd0);
        check_eq("abort_busy", 128'(busy), 128'(0));
        check_eq("abort_done", 128'(done), 128'(0));
        reset = 1'b0;
        for (int m = 0; m < 10; m++) exp_keys[m] = 128'd0;
        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        check_eq("post_reset_key10", key10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
